mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single RAM port between Core (read/write) and VGAcontrollerTop (read-only), inside MemoryController.
//  Grants at most one RAM access per clock and registers the RAM command.
//  Returns read data to the requester that issued each read.
//  VGA has priority for display deadlines; a starvation counter guarantees Core progress.
// PARAMETERS
//  ADDR_W         24  address width, both requesters and RAM
//  DATA_W         16  data width
//  RD_LAT          1  RAM read latency in cycles from command to ram_rdata valid (legal 1..4)
//  CORE_MAX_WAIT   4  consecutive cycles Core may be denied before a forced Core grant (legal 1..15)
// PORTS
//  clk          in   1       system clock, all logic rising-edge
//  rst          in   1       asynchronous, active-high reset
//  vga_req      in   1       VGA read request; hold with vga_addr stable until vga_ack
//  vga_addr     in   ADDR_W  VGA read address
//  vga_ack      out  1       combinational; request accepted this cycle
//  vga_rvalid   out  1       registered; vga_rdata valid this cycle
//  vga_rdata    out  DATA_W  registered VGA read data
//  core_req     in   1       Core request; hold with addr/we/wdata stable until core_ack
//  core_we      in   1       1 = write, 0 = read
//  core_addr    in   ADDR_W  Core address
//  core_wdata   in   DATA_W  Core write data
//  core_ack     out  1       combinational; request accepted this cycle
//  core_rvalid  out  1       registered; core_rdata valid (reads only)
//  core_rdata   out  DATA_W  registered Core read data
//  ram_addr     out  ADDR_W  registered RAM address
//  ram_we       out  1       registered RAM write strobe, one cycle per write
//  ram_wdata    out  DATA_W  registered RAM write data
//  ram_rdata    in   DATA_W  RAM read data, valid RD_LAT cycles after command
//  grant_owner  out  2       registered owner of command on RAM port: 00 none, 01 VGA, 10 Core
// BEHAVIOUR
//  Reset: all registered outputs 0; starvation counter 0; in-flight read tags cleared.
//   Reads in flight at reset never produce rvalid.
//  Arbitration (combinational, cycle N):
//   - Only one requester high: that requester is acked.
//   - Both high: VGA acked, unless wait_cnt == CORE_MAX_WAIT, then Core is acked.
//   - Neither high: no ack.
//   - vga_ack and core_ack are never high together; ack only while matching req is high.
//  wait_cnt: +1 each cycle core_req=1 and core_ack=0; cleared on core_ack or core_req=0; saturates at CORE_MAX_WAIT.
//  Command (cycle N+1): ram_addr/ram_we/ram_wdata/grant_owner are loaded from the acked request.
//   - Idle: grant_owner=00 and ram_we=0; ram_addr holds its last value.
//   - ram_we=1 only for an acked Core write; VGA never writes.
//  Back-to-back: a requester holding req high after ack presents a new request, full 1/cycle throughput.
//  Read return:
//   - A tag pipe of depth RD_LAT carries the owner of each read command.
//   - ram_rdata is captured in cycle N+1+RD_LAT.
//   - The owner's rvalid and rdata are asserted in cycle N+2+RD_LAT, one cycle wide.
//   - Reads return in issue order; rdata holds its value when rvalid=0.
//  Core write: no rvalid is generated.
//  FSM on grant_owner: NONE/VGA/CORE, next state = acked requester, else NONE; all transitions legal every cycle.
//  req dropped without ack: nothing issued, no error.
// TESTING
//  1. VGA only, vga_addr=0x000100, req 1 cycle, RD_LAT=1, ram_rdata=0xBEEF:
//     -> vga_ack in cycle 0; ram_addr=0x000100 in cycle 1; vga_rvalid with 0xBEEF in cycle 3.
//  2. Core write addr=0x000010 data=0x1234:
//     -> core_ack cycle 0; cycle 1 ram_we=1, ram_wdata=0x1234, grant_owner=10; core_rvalid never asserted.
//  3. Both req held continuously, CORE_MAX_WAIT=4:
//     -> VGA acked cycles 0-3, Core acked cycle 4, VGA cycle 5 onward.
//     -> pattern repeats every 5 cycles; acks never overlap.
//  4. Interleaved VGA read A=0x20 and Core read B=0x40 on consecutive cycles, ram returns 0xAAAA then 0xBBBB:
//     -> vga_rdata=0xAAAA one cycle before core_rdata=0xBBBB; no cross-delivery.
//  5. rst pulsed 1 cycle after a Core read is acked:
//     -> all outputs 0 immediately; no core_rvalid afterwards; next request after rst served normally.
//  6. RD_LAT=3, VGA reads back-to-back 8 cycles:
//     -> 8 consecutive vga_rvalid pulses, first at cycle 5, data in address order.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between VGA (read-only, priority) and Core (read/write).
// One registered command per cycle; read data is steered back to the issuer via a tag pipe.
module mem_arbiter #(
  parameter int ADDR_W        = 24,
  parameter int DATA_W        = 16,
  parameter int RD_LAT        = 1,
  parameter int CORE_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        grant_owner
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_VGA  = 2'b01,
    OWN_CORE = 2'b10
  } owner_e;

  localparam logic [3:0] WAIT_MAX = 4'(CORE_MAX_WAIT);

  owner_e              state_q, state_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_we_q, ram_we_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  owner_e              tag_q [RD_LAT];
  owner_e              tag_d [RD_LAT];
  owner_e              rd_owner, ret_owner;
  logic                vga_rvalid_q, vga_rvalid_d;
  logic [DATA_W-1:0]   vga_rdata_q, vga_rdata_d;
  logic                core_rvalid_q, core_rvalid_d;
  logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
  logic                core_force;

  // Core wins a contended cycle only once it has been starved for WAIT_MAX cycles
  assign core_force = core_req && (wait_cnt_q == WAIT_MAX);
  assign vga_ack    = vga_req && !core_force;
  assign core_ack   = core_req && (!vga_req || core_force);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!core_req || core_ack) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_comb begin
    state_d     = OWN_NONE;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    if (vga_ack) begin
      state_d    = OWN_VGA;
      ram_addr_d = vga_addr;
    end else if (core_ack) begin
      state_d    = OWN_CORE;
      ram_addr_d = core_addr;
      ram_we_d   = core_we;
      if (core_we) begin
        ram_wdata_d = core_wdata;
      end
    end
  end

  // The command register is the first stage; the tag pipe covers the RAM latency
  always_comb begin
    rd_owner = OWN_NONE;
    if (state_q == OWN_VGA) begin
      rd_owner = OWN_VGA;
    end else if (state_q == OWN_CORE && !ram_we_q) begin
      rd_owner = OWN_CORE;
    end
  end

  always_comb begin
    for (int i = 0; i < RD_LAT; i++) begin
      tag_d[i] = OWN_NONE;
    end
    tag_d[0] = rd_owner;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  assign ret_owner = tag_q[RD_LAT-1];

  always_comb begin
    vga_rvalid_d  = (ret_owner == OWN_VGA);
    core_rvalid_d = (ret_owner == OWN_CORE);
    vga_rdata_d   = vga_rdata_q;
    core_rdata_d  = core_rdata_q;
    if (ret_owner == OWN_VGA) begin
      vga_rdata_d = ram_rdata;
    end
    if (ret_owner == OWN_CORE) begin
      core_rdata_d = ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= OWN_NONE;
      wait_cnt_q    <= 4'd0;
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= '0;
      vga_rvalid_q  <= 1'b0;
      vga_rdata_q   <= '0;
      core_rvalid_q <= 1'b0;
      core_rdata_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= OWN_NONE;
      end
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
      vga_rvalid_q  <= vga_rvalid_d;
      vga_rdata_q   <= vga_rdata_d;
      core_rvalid_q <= core_rvalid_d;
      core_rdata_q  <= core_rdata_d;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign grant_owner = state_q;
  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_wdata   = ram_wdata_q;
  assign vga_rvalid  = vga_rvalid_q;
  assign vga_rdata   = vga_rdata_q;
  assign core_rvalid = core_rvalid_q;
  assign core_rdata  = core_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RD_LAT=1, one with RD_LAT=3.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // RD_LAT=1 instance
  logic        v1_req = 1'b0;
  logic [23:0] v1_addr = '0;
  logic        v1_ack, v1_rvalid;
  logic [15:0] v1_rdata;
  logic        c1_req = 1'b0, c1_we = 1'b0;
  logic [23:0] c1_addr = '0;
  logic [15:0] c1_wdata = '0;
  logic        c1_ack, c1_rvalid;
  logic [15:0] c1_rdata;
  logic [23:0] r1_addr;
  logic        r1_we;
  logic [15:0] r1_wdata, r1_rdata;
  logic [1:0]  own1;

  // RD_LAT=3 instance
  logic        v3_req = 1'b0;
  logic [23:0] v3_addr = '0;
  logic        v3_ack, v3_rvalid;
  logic [15:0] v3_rdata;
  logic        c3_ack, c3_rvalid;
  logic [15:0] c3_rdata;
  logic [23:0] r3_addr;
  logic        r3_we;
  logic [15:0] r3_wdata, r3_rdata;
  logic [1:0]  own3;

  mem_arbiter #(.ADDR_W(24), .DATA_W(16), .RD_LAT(1), .CORE_MAX_WAIT(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .vga_req(v1_req), .vga_addr(v1_addr), .vga_ack(v1_ack),
    .vga_rvalid(v1_rvalid), .vga_rdata(v1_rdata),
    .core_req(c1_req), .core_we(c1_we), .core_addr(c1_addr), .core_wdata(c1_wdata),
    .core_ack(c1_ack), .core_rvalid(c1_rvalid), .core_rdata(c1_rdata),
    .ram_addr(r1_addr), .ram_we(r1_we), .ram_wdata(r1_wdata), .ram_rdata(r1_rdata),
    .grant_owner(own1)
  );

  mem_arbiter #(.ADDR_W(24), .DATA_W(16), .RD_LAT(3), .CORE_MAX_WAIT(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .vga_req(v3_req), .vga_addr(v3_addr), .vga_ack(v3_ack),
    .vga_rvalid(v3_rvalid), .vga_rdata(v3_rdata),
    .core_req(1'b0), .core_we(1'b0), .core_addr(24'h0), .core_wdata(16'h0),
    .core_ack(c3_ack), .core_rvalid(c3_rvalid), .core_rdata(c3_rdata),
    .ram_addr(r3_addr), .ram_we(r3_we), .ram_wdata(r3_wdata), .ram_rdata(r3_rdata),
    .grant_owner(own3)
  );

  // Read-only RAM model: content is a fixed function of the address
  function automatic logic [15:0] ram_val(input logic [23:0] a);
    case (a)
      24'h000100: ram_val = 16'hBEEF;
      24'h000020: ram_val = 16'hAAAA;
      24'h000040: ram_val = 16'hBBBB;
      default:    ram_val = 16'hC000 | {4'h0, a[11:0]};
    endcase
  endfunction

  logic [15:0] p1;
  logic [15:0] p3 [3];
  always @(posedge clk) begin
    p1    <= ram_val(r1_addr);
    p3[0] <= ram_val(r3_addr);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign r1_rdata = p1;
  assign r3_rdata = p3[2];

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nxt();
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({own1, r1_we, r1_addr, r1_wdata, v1_rvalid, v1_rdata, c1_rvalid, c1_rdata} !== '0) begin
      n_errors++;
      $display("FAIL reset_dut1: own=%b we=%b addr=%h vrv=%b crv=%b, required all zero",
               own1, r1_we, r1_addr, v1_rvalid, c1_rvalid);
    end
    n_checks++;
    if ({own3, r3_we, r3_addr, r3_wdata, v3_rvalid, v3_rdata, c3_rvalid, c3_rdata} !== '0) begin
      n_errors++;
      $display("FAIL reset_dut3: own=%b we=%b addr=%h vrv=%b, required all zero",
               own3, r3_we, r3_addr, v3_rvalid);
    end
    nxt();
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_vga_read;
    v1_req = 1'b1; v1_addr = 24'h000100;
    @(negedge clk);
    n_checks++;
    if (v1_ack !== 1'b1 || c1_ack !== 1'b0) begin
      n_errors++; $display("FAIL vga_ack: vga_ack=%b core_ack=%b, required 1/0", v1_ack, c1_ack);
    end
    nxt(); v1_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (r1_addr !== 24'h000100 || own1 !== 2'b01 || r1_we !== 1'b0) begin
      n_errors++; $display("FAIL vga_cmd: addr=%h own=%b we=%b, required 000100/01/0", r1_addr, own1, r1_we);
    end
    nxt(); @(negedge clk);
    n_checks++;
    if (v1_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL vga_early: rvalid=%b in cycle 2, required 0", v1_rvalid);
    end
    nxt(); @(negedge clk);
    n_checks++;
    if (v1_rvalid !== 1'b1 || v1_rdata !== 16'hBEEF || c1_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL vga_return: rvalid=%b rdata=%h core_rvalid=%b, required 1/beef/0",
                           v1_rvalid, v1_rdata, c1_rvalid);
    end
    nxt(); @(negedge clk);
    n_checks++;
    if (v1_rvalid !== 1'b0 || v1_rdata !== 16'hBEEF || own1 !== 2'b00) begin
      n_errors++; $display("FAIL vga_after: rvalid=%b rdata=%h own=%b, required 0/beef/00",
                           v1_rvalid, v1_rdata, own1);
    end
    nxt();
  endtask

  task automatic test_core_write;
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 24'h000010; c1_wdata = 16'h1234;
    @(negedge clk);
    n_checks++;
    if (c1_ack !== 1'b1 || v1_ack !== 1'b0) begin
      n_errors++; $display("FAIL core_ack: core_ack=%b vga_ack=%b, required 1/0", c1_ack, v1_ack);
    end
    nxt(); c1_req = 1'b0; c1_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (r1_we !== 1'b1 || r1_wdata !== 16'h1234 || r1_addr !== 24'h000010 || own1 !== 2'b10) begin
      n_errors++; $display("FAIL core_wr_cmd: we=%b wdata=%h addr=%h own=%b, required 1/1234/000010/10",
                           r1_we, r1_wdata, r1_addr, own1);
    end
    nxt(); @(negedge clk);
    n_checks++;
    if (r1_we !== 1'b0 || own1 !== 2'b00 || r1_addr !== 24'h000010) begin
      n_errors++; $display("FAIL core_wr_idle: we=%b own=%b addr=%h, required 0/00/000010", r1_we, own1, r1_addr);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (c1_rvalid !== 1'b0) begin
        n_errors++; $display("FAIL core_wr_norvalid: core_rvalid=%b at step %0d, required 0", c1_rvalid, i);
      end
      nxt(); @(negedge clk);
    end
    nxt();
  endtask

  task automatic test_starvation;
    v1_req = 1'b1; v1_addr = 24'h000050;
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 24'h000060;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      n_checks++;
      if (v1_ack !== (c % 5 != 4) || c1_ack !== (c % 5 == 4)) begin
        n_errors++; $display("FAIL starve_c%0d: vga_ack=%b core_ack=%b, required %b/%b",
                             c, v1_ack, c1_ack, (c % 5 != 4), (c % 5 == 4));
      end
      nxt();
    end
    v1_req = 1'b0; c1_req = 1'b0;
    idle(4);
  endtask

  task automatic test_drop;
    v1_req = 1'b1; v1_addr = 24'h000070;
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 24'h000080; c1_wdata = 16'h5555;
    @(negedge clk);
    n_checks++;
    if (v1_ack !== 1'b1 || c1_ack !== 1'b0) begin
      n_errors++; $display("FAIL drop_arb: vga_ack=%b core_ack=%b, required 1/0", v1_ack, c1_ack);
    end
    nxt(); v1_req = 1'b0; c1_req = 1'b0; c1_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (own1 !== 2'b01 || r1_we !== 1'b0) begin
      n_errors++; $display("FAIL drop_cmd: own=%b we=%b, required 01/0", own1, r1_we);
    end
    nxt(); @(negedge clk);
    n_checks++;
    if (own1 !== 2'b00 || r1_we !== 1'b0 || r1_addr !== 24'h000070) begin
      n_errors++; $display("FAIL drop_idle: own=%b we=%b addr=%h, required 00/0/000070", own1, r1_we, r1_addr);
    end
    idle(4);
  endtask

  task automatic test_interleave;
    v1_req = 1'b1; v1_addr = 24'h000020;
    @(negedge clk);
    n_checks++;
    if (v1_ack !== 1'b1) begin
      n_errors++; $display("FAIL il_vga_ack: vga_ack=%b, required 1", v1_ack);
    end
    nxt(); v1_req = 1'b0; c1_req = 1'b1; c1_we = 1'b0; c1_addr = 24'h000040;
    @(negedge clk);
    n_checks++;
    if (c1_ack !== 1'b1) begin
      n_errors++; $display("FAIL il_core_ack: core_ack=%b, required 1", c1_ack);
    end
    nxt(); c1_req = 1'b0;
    nxt(); @(negedge clk);
    n_checks++;
    if (v1_rvalid !== 1'b1 || v1_rdata !== 16'hAAAA || c1_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL il_vga_ret: vrv=%b vdata=%h crv=%b, required 1/aaaa/0", v1_rvalid, v1_rdata, c1_rvalid);
    end
    nxt(); @(negedge clk);
    n_checks++;
    if (c1_rvalid !== 1'b1 || c1_rdata !== 16'hBBBB || v1_rvalid !== 1'b0 || v1_rdata !== 16'hAAAA) begin
      n_errors++; $display("FAIL il_core_ret: crv=%b cdata=%h vrv=%b vdata=%h, required 1/bbbb/0/aaaa",
                           c1_rvalid, c1_rdata, v1_rvalid, v1_rdata);
    end
    idle(3);
  endtask

  task automatic test_reset_inflight;
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 24'h000040;
    @(negedge clk);
    n_checks++;
    if (c1_ack !== 1'b1) begin
      n_errors++; $display("FAIL rst_pre_ack: core_ack=%b, required 1", c1_ack);
    end
    nxt(); c1_req = 1'b0; rst = 1'b1;
    #1;
    n_checks++;
    if ({own1, r1_we, r1_addr, r1_wdata, v1_rvalid, v1_rdata, c1_rvalid, c1_rdata} !== '0) begin
      n_errors++; $display("FAIL rst_async: own=%b addr=%h wdata=%h vdata=%h cdata=%h, required all zero",
                           own1, r1_addr, r1_wdata, v1_rdata, c1_rdata);
    end
    nxt(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (c1_rvalid !== 1'b0) begin
        n_errors++; $display("FAIL rst_no_rvalid: core_rvalid=%b at step %0d, required 0", c1_rvalid, i);
      end
      nxt();
    end
    c1_req = 1'b1; c1_addr = 24'h000040;
    nxt(); c1_req = 1'b0;
    nxt(); nxt(); @(negedge clk);
    n_checks++;
    if (c1_rvalid !== 1'b1 || c1_rdata !== 16'hBBBB) begin
      n_errors++; $display("FAIL rst_recover: core_rvalid=%b core_rdata=%h, required 1/bbbb", c1_rvalid, c1_rdata);
    end
    idle(3);
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 15; c++) begin
      v3_req  = (c < 8);
      v3_addr = 24'h000300 + 24'(c);
      @(negedge clk);
      n_checks++;
      if (v3_rvalid !== (c >= 5 && c <= 12)) begin
        n_errors++; $display("FAIL b2b_rvalid_c%0d: rvalid=%b, required %b", c, v3_rvalid, (c >= 5 && c <= 12));
      end
      if (c >= 5 && c <= 12) begin
        n_checks++;
        if (v3_rdata !== 16'hC300 + 16'(c - 5)) begin
          n_errors++; $display("FAIL b2b_rdata_c%0d: rdata=%h, required %h", c, v3_rdata, 16'hC300 + 16'(c - 5));
        end
      end
      nxt();
    end
    v3_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vga_read();
    test_core_write();
    test_starvation();
    test_drop();
    test_interleave();
    test_reset_inflight();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
